// File: rtl/wb_arbiter_pkg.sv
// Shared write-back types and the op-age comparison.
// The PRF and the write-back arbiter both import this package.
package types;

    typedef struct packed {
        logic [15:0] opid;   // bit 15 = valid, low bits = op ID
        logic [6:0]  prd;    // destination physical register
        logic [31:0] data;   // result value
    } exe_bundle_t;

    typedef struct packed {
        logic [15:0] opid;   // redirecting op, bit 15 = redirect valid
        logic [15:0] topid;  // oldest op still in flight
    } red_bundle_t;

    // True when x is strictly younger than the redirecting op.
    // Distances are taken from topid modulo opsz, so wrapped IDs order correctly.
    function automatic logic younger(input red_bundle_t red, input logic [15:0] x,
                                     input int opsz);
        logic [15:0] mask;
        logic [15:0] dist_x;
        logic [15:0] dist_r;
        mask   = 16'(opsz - 1);
        dist_x = (x - red.topid) & mask;
        dist_r = (red.opid - red.topid + 16'd1) & mask;
        return red.opid[15] & x[15] & (dist_x >= dist_r);
    endfunction

endpackage

// File: rtl/wb_queue.sv
// Per-source result FIFO with per-entry squash on redirect.
// Heads that were squashed are popped as bubbles without taking a write slot.
module wb_queue
    import types::*;
#(
    parameter int qdep = 4,
    parameter int opsz = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  exe_bundle_t in_bundle,
    output logic        ready,
    input  red_bundle_t red_bundle,
    output exe_bundle_t head,
    output logic        head_live,
    input  logic        grant
);

    localparam int aw = $clog2(qdep);
    localparam int cw = aw + 1;

    exe_bundle_t     mem [qdep];
    logic [qdep-1:0] vld;
    logic [aw-1:0]   rd_ptr;
    logic [aw-1:0]   wr_ptr;
    logic [cw-1:0]   count;
    logic            present;
    logic            accept;
    logic            pop;

    // Ready comes from registered occupancy only; a same-cycle pop gives no credit.
    assign ready     = (count < cw'(qdep));
    assign present   = (count != '0);
    assign head      = mem[rd_ptr];
    assign head_live = present & vld[rd_ptr] & ~younger(red_bundle, mem[rd_ptr].opid, opsz);
    assign accept    = in_bundle.opid[15] & ready & ~younger(red_bundle, in_bundle.opid, opsz);
    assign pop       = grant | (present & ~head_live);

    // Payload storage, written only when a result is accepted.
    // NOTE: the payload array has no reset; count and vld decide which entries are live,
    // so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr] <= in_bundle;
        end
    end

    // Pointers, occupancy and per-entry valid bits, with squash on redirect.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            vld    <= '0;
        end else begin
            for (int j = 0; j < qdep; j++) begin
                if (younger(red_bundle, mem[j].opid, opsz)) begin
                    vld[j] <= 1'b0;
                end
            end
            if (accept) begin
                vld[wr_ptr] <= 1'b1;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({accept, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: fus result queues feed ewd PRF write slots.
// Round-robin grant, slots packed from 0 upward, squashed heads masked.
module wb_arbiter
    import types::*;
#(
    parameter int fus  = 4,
    parameter int ewd  = 2,
    parameter int qdep = 4,
    parameter int opsz = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  exe_bundle_t     fu_bundle [fus],
    output logic [fus-1:0]  fu_ready,
    input  red_bundle_t     red_bundle,
    output exe_bundle_t     exe_bundle [ewd]
);

    localparam int rw = (fus > 1) ? $clog2(fus) : 1;
    localparam int sw = (ewd > 1) ? $clog2(ewd) : 1;

    exe_bundle_t    head [fus];
    logic [fus-1:0] head_live;
    logic [fus-1:0] grant;
    logic [rw-1:0]  rr;
    logic [rw-1:0]  rr_next;

    for (genvar i = 0; i < fus; i++) begin : g_queue
        wb_queue #(
            .qdep (qdep),
            .opsz (opsz)
        ) u_queue (
            .clk        (clk),
            .rst        (rst),
            .in_bundle  (fu_bundle[i]),
            .ready      (fu_ready[i]),
            .red_bundle (red_bundle),
            .head       (head[i]),
            .head_live  (head_live[i]),
            .grant      (grant[i])
        );
    end

    // Round-robin search from rr, filling up to ewd slots from live queue heads.
    always_comb begin
        int            taken;
        int            sum;
        logic [rw-1:0] idx;
        logic [sw-1:0] slot;
        // NOTE: every output and temporary gets a default before the search loop,
        // so no path leaves anything unassigned and no latch is inferred.
        taken   = 0;
        sum     = 0;
        idx     = '0;
        slot    = '0;
        grant   = '0;
        rr_next = rr;
        for (int s = 0; s < ewd; s++) begin
            exe_bundle[s] = '0;
        end
        // NOTE: blocking assignments here; taken/idx are running values within one
        // evaluation, not state, so each iteration must see the previous one's update.
        for (int k = 0; k < fus; k++) begin
            sum = int'(rr) + k;
            if (sum >= fus) begin
                sum = sum - fus;
            end
            idx = rw'(sum);
            if (!rst && head_live[idx] && (taken < ewd)) begin
                slot             = sw'(taken);
                grant[idx]       = 1'b1;
                exe_bundle[slot] = head[idx];
                taken            = taken + 1;
                rr_next          = (idx == rw'(fus - 1)) ? '0 : idx + 1'b1;
            end
        end
    end

    // Round-robin pointer: moves past the last granted source, holds when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr <= '0;
        end else begin
            rr <= rr_next;
        end
    end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter fus, none, number of functional-unit result sources (>= 1).
REQ-002 Parameter ewd, none, PRF write ports, i.e. output slots per cycle (1 <= ewd <= fus).
REQ-003 Parameter qdep, none, per-source queue depth, power of two, >= 2.
REQ-004 Parameter opsz, none, operation ID space size, power of two.
REQ-005 clk  input  1  sole clock; all state updates on posedge clk.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 fu_bundle  input  exe_bundle_t[fus]  FU results; valid when opid[15] is set.
REQ-008 fu_ready  output  [fus]  source i may present a result this cycle.
REQ-009 red_bundle  input  red_bundle_t  pipeline redirect; valid when opid[15] is set; topid is the oldest in-flight ID.
REQ-010 exe_bundle  output  exe_bundle_t[ewd]  write-back to PRF/busy table; slot valid when opid[15] is set.

Function
REQ-011 Source i's result is accepted when fu_bundle[i].opid[15] & fu_ready[i]; a valid result with fu_ready[i]=0 is ignored, and the FU holds it.
REQ-012 fu_ready[i] = (occupancy of queue i < qdep), from registered state only; no same-cycle dequeue credit.
REQ-013 Each source has a FIFO of depth qdep; per-source order is preserved end to end.
REQ-014 Each cycle, up to ewd output slots are filled combinationally from queue heads; each source contributes at most one entry per cycle.
REQ-015 Grant is round-robin: search starts at pointer rr, rr advances to (last granted source + 1) mod fus; rr stays unchanged if nothing is granted.
REQ-016 Granted slots are packed from slot 0 upward; unused slots drive opid[15]=0 with all other fields zero.
REQ-017 Granted heads are dequeued at the same posedge.
REQ-018 Latency: a result accepted at edge t appears on exe_bundle in cycle t+1 at the earliest; an uncongested source gets exactly 1 cycle.
REQ-019 Younger(x) = red.opid[15] & x[15] & ((x - topid) mod opsz >= (red.opid - topid + 1) mod opsz), computed at $clog2(opsz) bits.
REQ-020 While redirect is valid, queued entries with Younger(opid) have their valid bit cleared at the edge; they are also masked from exe_bundle in that same cycle and do not consume a slot.
REQ-021 While redirect is valid, incoming fu_bundle results with Younger(opid) are dropped and not enqueued; fu_ready is unaffected.
REQ-022 The redirecting op itself and older ops are never squashed.
REQ-023 A head with valid bit clear is popped without taking a slot; at most one such bubble pops per source per cycle.
REQ-024 Simultaneous enqueue and dequeue on a full queue: enqueue is refused (REQ-012) and dequeue proceeds.
REQ-025 Pointer and occupancy wrap modulo qdep; occupancy width is $clog2(qdep)+1.

Reset
REQ-026 On rst, all queues empty, valid bits clear, rr=0, fu_ready all 1 in the next cycle, exe_bundle all invalid in the next cycle.
REQ-027 rst overrides a simultaneous enqueue, dequeue or redirect; in-flight results are discarded.

Structure
REQ-028 exe_bundle_t, red_bundle_t and the Younger() comparison function live in package types; prf and this block share Younger().
REQ-029 The per-source FIFO with per-entry squash is sub-module wb_queue, instantiated fus times; arbitration lives in wb_arbiter.

Verification (fus=4, ewd=2, qdep=4, opsz=64)
REQ-030 Single result, opid=0x8005 on source 2 at edge 0 -> exe_bundle[0].opid=0x8005 in cycle 1, slot 1 invalid.
REQ-031 All 4 sources valid every cycle for 8 cycles -> exactly 2 writes per cycle, grants rotate {0,1},{2,3},{0,1}..., per-source order preserved, fu_ready drops only after a queue holds 4 entries.
REQ-032 Source 0 queue holds 4 entries with no grant (sources 1-3 saturating) -> fu_ready[0]=0; a fifth offer is not accepted and is re-accepted once occupancy is 3.
REQ-033 topid=0x8010, queued opids 0x8012, 0x8015, 0x8018, redirect opid=0x8015 -> 0x8018 never appears; 0x8012 and 0x8015 are written.
REQ-034 Wrap-around IDs: topid=0x803E, redirect opid=0x803F, incoming opid=0x8001 -> dropped; incoming opid=0x803E -> kept.
REQ-035 rst asserted with 3 entries queued -> no further exe_bundle valid slot, and all fu_ready=1 after reset.
